// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the femtoRV32 multi-cycle control sequencer:
// IR field positions, FSM states, opcodes and datapath select codes.
package multicycle_ctrl_fsm_pkg;

  localparam int IR_OPCODE_MSB = 6;
  localparam int IR_OPCODE_LSB = 2;
  localparam int IR_FUNCT3_MSB = 14;
  localparam int IR_FUNCT3_LSB = 12;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [4:0] OPC_LOAD       = 5'b00000;
  localparam logic [4:0] OPC_STORE      = 5'b01000;
  localparam logic [4:0] OPC_BRANCH     = 5'b11000;
  localparam logic [4:0] OPC_JALR       = 5'b11001;
  localparam logic [4:0] OPC_JAL        = 5'b11011;
  localparam logic [4:0] OPC_ARITH_I    = 5'b00100;
  localparam logic [4:0] OPC_ARITH_R    = 5'b01100;
  localparam logic [4:0] OPC_AUIPC      = 5'b00101;
  localparam logic [4:0] OPC_LUI        = 5'b01101;
  localparam logic [4:0] OPC_SYSTEM     = 5'b11100;
  localparam logic [4:0] OPC_CUSTOM_NOP = 5'b10001;

  localparam logic [1:0] PC_SEL_PC4     = 2'b00;
  localparam logic [1:0] PC_SEL_PC_IMM  = 2'b01;
  localparam logic [1:0] PC_SEL_RS1_IMM = 2'b10;
  localparam logic [1:0] PC_SEL_HOLD    = 2'b11;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ARITH_R,
    CLS_ARITH_I, CLS_AUIPC, CLS_LUI, CLS_SYSTEM, CLS_NOP, CLS_ILLEGAL
  } op_cls_t;

  typedef struct packed {
    logic [1:0] op;
    logic       src;
    logic       auipc;
  } alu_sel_t;

  function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
    return ir[IR_OPCODE_MSB:IR_OPCODE_LSB];
  endfunction

  function automatic logic [2:0] ir_funct3(input logic [31:0] ir);
    return ir[IR_FUNCT3_MSB:IR_FUNCT3_LSB];
  endfunction

  function automatic op_cls_t classify(input logic [4:0] opc);
    case (opc)
      OPC_LOAD:       return CLS_LOAD;
      OPC_STORE:      return CLS_STORE;
      OPC_BRANCH:     return CLS_BRANCH;
      OPC_JAL:        return CLS_JAL;
      OPC_JALR:       return CLS_JALR;
      OPC_ARITH_R:    return CLS_ARITH_R;
      OPC_ARITH_I:    return CLS_ARITH_I;
      OPC_AUIPC:      return CLS_AUIPC;
      OPC_LUI:        return CLS_LUI;
      OPC_SYSTEM:     return CLS_SYSTEM;
      OPC_CUSTOM_NOP: return CLS_NOP;
      default:        return CLS_ILLEGAL;
    endcase
  endfunction

  // ALU op / B source / A source per instruction class; jumps leave them at add/rs2/rs1.
  function automatic alu_sel_t alu_sel(input op_cls_t c);
    case (c)
      CLS_ARITH_R:          return '{op: ALUOP_FUNCT,  src: 1'b0, auipc: 1'b0};
      CLS_ARITH_I:          return '{op: ALUOP_FUNCT,  src: 1'b1, auipc: 1'b0};
      CLS_LOAD, CLS_STORE:  return '{op: ALUOP_ADD,    src: 1'b1, auipc: 1'b0};
      CLS_AUIPC:            return '{op: ALUOP_ADD,    src: 1'b1, auipc: 1'b1};
      CLS_LUI:              return '{op: ALUOP_IMM,    src: 1'b1, auipc: 1'b0};
      CLS_BRANCH:           return '{op: ALUOP_BRANCH, src: 1'b0, auipc: 1'b0};
      default:              return '{op: ALUOP_ADD,    src: 1'b0, auipc: 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_watchdog.sv
// Memory watchdog: counts cycles a request waits without ready and flags
// a timeout once the count reaches MEM_TIMEOUT. Ready in the same cycle wins.
module mem_watchdog
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  logic [TO_W-1:0] cnt_q;

  // Wait counter: clears when idle or served, otherwise saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (!req || ready)    cnt_q <= '0;
    else if (cnt_q != '1)      cnt_q <= cnt_q + 1'b1;
  end

  assign timeout = (MEM_TIMEOUT > 0) && req && !ready &&
                   (cnt_q == TO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared
// variable-latency memory port, with watchdog and sticky halt status.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 0,
  parameter int TO_W            = 8,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       auipc_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       halted,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [2:0] state
);

  state_t   state_q, state_d;
  op_cls_t  cls;
  alu_sel_t asel;
  logic     wd_timeout, set_illegal, set_timeout;
  logic     halted_q, illegal_q, timeout_q;
  logic     funct3_unused;

  // funct3 only sizes loads/stores in the datapath; nothing here decodes it.
  assign funct3_unused = ^funct3;

  assign cls   = classify(opcode);
  assign asel  = alu_sel(cls);
  assign state = state_q;

  mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (mem_req),
    .ready   (mem_ready),
    .timeout (wd_timeout)
  );

  // State register; reset lands in RST so every strobe drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RST;
    else        state_q <= state_d;
  end

  // Sticky status: halted follows any entry into HALT, causes recorded separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      halted_q  <= halted_q  | (state_d == ST_HALT);
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | set_timeout;
    end
  end

  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;

  // Next state and per-state strobes; pc_we and retire always move together.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PC4;
    alu_op       = ALUOP_ADD;
    alu_src      = 1'b0;
    auipc_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_SEL_ALU;
    retire       = 1'b0;
    set_illegal  = 1'b0;
    set_timeout  = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (wd_timeout) begin
          set_timeout = 1'b1;
          state_d     = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (cls == CLS_SYSTEM) begin
          state_d = ST_HALT;
        end else if (cls == CLS_ILLEGAL && HALT_ON_ILLEGAL != 0) begin
          set_illegal = 1'b1;
          state_d     = ST_HALT;
        end else if (cls == CLS_NOP || cls == CLS_ILLEGAL) begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        {alu_op, alu_src, auipc_sel} = asel;
        case (cls)
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PC_SEL_PC_IMM : PC_SEL_PC4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CLS_JAL, CLS_JALR: begin
            reg_we  = 1'b1;
            wb_sel  = WB_SEL_PC4;
            pc_we   = 1'b1;
            pc_sel  = (cls == CLS_JAL) ? PC_SEL_PC_IMM : PC_SEL_RS1_IMM;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        // Selects stay put so the effective address is stable for the access.
        {alu_op, alu_src, auipc_sel} = asel;
        mem_req = 1'b1;
        mem_we  = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (wd_timeout) begin
          set_timeout = 1'b1;
          state_d     = ST_HALT;
        end
      end
      ST_WB: begin
        // Keep the ALU result feeding the write-back mux stable.
        {alu_op, alu_src, auipc_sel} = asel;
        reg_we  = 1'b1;
        wb_sel  = (cls == CLS_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: pc_sel = PC_SEL_HOLD;
      default: state_d = ST_HALT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench: two instances (A: MEM_TIMEOUT=4, HALT_ON_ILLEGAL=1; B: watchdog off,
// illegal-as-NOP) share stimulus. Each instruction is expanded into its
// expected per-cycle output trace and checked every cycle.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, isf, irwe, pcwe;
    logic [1:0] pcsel, aluop;
    logic       src, aui, regwe;
    logic [1:0] wbsel;
    logic       ret, hlt, ill, mto;
  } rec_t;

  typedef struct packed {
    rec_t a;
    rec_t b;
    logic achk;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;

  logic a_req, a_we, a_isf, a_irwe, a_pcwe, a_src, a_aui, a_regwe, a_ret, a_hlt, a_ill, a_mto;
  logic b_req, b_we, b_isf, b_irwe, b_pcwe, b_src, b_aui, b_regwe, b_ret, b_hlt, b_ill, b_mto;
  logic [1:0] a_pcsel, a_aluop, a_wbsel, b_pcsel, b_aluop, b_wbsel;
  logic [2:0] a_state, b_state;

  int checks = 0;
  int errors = 0;
  int ret_a = 0;
  int ret_b = 0;

  ent_t q[$];
  rec_t pl[$];
  bit   pr[$];
  bit   pc[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .TO_W(8), .HALT_ON_ILLEGAL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(a_req), .mem_we(a_we), .mem_is_fetch(a_isf), .ir_we(a_irwe),
    .pc_we(a_pcwe), .pc_sel(a_pcsel), .alu_op(a_aluop), .alu_src(a_src),
    .auipc_sel(a_aui), .reg_we(a_regwe), .wb_sel(a_wbsel), .retire(a_ret),
    .halted(a_hlt), .illegal(a_ill), .mem_timeout(a_mto), .state(a_state));

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(0), .TO_W(8), .HALT_ON_ILLEGAL(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(b_req), .mem_we(b_we), .mem_is_fetch(b_isf), .ir_we(b_irwe),
    .pc_we(b_pcwe), .pc_sel(b_pcsel), .alu_op(b_aluop), .alu_src(b_src),
    .auipc_sel(b_aui), .reg_we(b_regwe), .wb_sel(b_wbsel), .retire(b_ret),
    .halted(b_hlt), .illegal(b_ill), .mem_timeout(b_mto), .state(b_state));

  function automatic rec_t act_a();
    return '{st: a_state, req: a_req, we: a_we, isf: a_isf, irwe: a_irwe, pcwe: a_pcwe,
             pcsel: a_pcsel, aluop: a_aluop, src: a_src, aui: a_aui, regwe: a_regwe,
             wbsel: a_wbsel, ret: a_ret, hlt: a_hlt, ill: a_ill, mto: a_mto};
  endfunction

  function automatic rec_t act_b();
    return '{st: b_state, req: b_req, we: b_we, isf: b_isf, irwe: b_irwe, pcwe: b_pcwe,
             pcsel: b_pcsel, aluop: b_aluop, src: b_src, aui: b_aui, regwe: b_regwe,
             wbsel: b_wbsel, ret: b_ret, hlt: b_hlt, ill: b_ill, mto: b_mto};
  endfunction

  task automatic cmp(input string nm, input rec_t act, input rec_t exp, input bit achk);
    rec_t a = act;
    if (!achk) begin
      a.aluop = exp.aluop;
      a.src   = exp.src;
      a.aui   = exp.aui;
    end
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h (fields st,req,we,isf,irwe,pcwe,pcsel,aluop,src,aui,regwe,wbsel,ret,hlt,ill,mto)",
               nm, $time, a, exp);
    end
  endtask

  task automatic chk_lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the expected trace.
  always @(negedge clk) begin : cmp_proc
    ent_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("dutA_cycle", act_a(), e.a, e.achk);
      cmp("dutB_cycle", act_b(), e.b, e.achk);
      if (a_ret) ret_a++;
      if (b_ret) ret_b++;
    end
  end

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit known(input logic [4:0] o);
    return o inside {5'b00000, 5'b01000, 5'b11000, 5'b11001, 5'b11011, 5'b00100,
                     5'b01100, 5'b00101, 5'b01101, 5'b11100, 5'b10001};
  endfunction

  function automatic rec_t r_fetch();
    rec_t e = '0;
    e.st = 3'd1; e.req = 1'b1; e.isf = 1'b1;
    return e;
  endfunction

  function automatic rec_t r_halt(input bit ill, input bit mto);
    rec_t e = '0;
    e.st = 3'd6; e.pcsel = 2'd3; e.hlt = 1'b1; e.ill = ill; e.mto = mto;
    return e;
  endfunction

  task automatic pp(input rec_t e, input bit r, input bit chk);
    pl.push_back(e); pr.push_back(r); pc.push_back(chk);
  endtask

  // Expand one instruction into the cycle trace the rules require (no watchdog expiry).
  task automatic plan(input logic [4:0] opc, input bit tk, input int fw, input int mw, input bit hoi);
    rec_t e;
    bit ld = (opc == 5'b00000);
    bit sto = (opc == 5'b01000);
    pl.delete(); pr.delete(); pc.delete();
    for (int i = 0; i < fw; i++) pp(r_fetch(), 1'b0, 1'b1);
    e = r_fetch(); e.irwe = 1'b1; pp(e, 1'b1, 1'b1);
    e = '0; e.st = 3'd2;
    if (opc == 5'b11100) begin pp(e, rb(), 1'b1); return; end
    if (opc == 5'b10001 || (!known(opc) && !hoi)) begin
      e.pcwe = 1'b1; e.ret = 1'b1; pp(e, rb(), 1'b1); return;
    end
    pp(e, rb(), 1'b1);
    if (!known(opc)) return;
    e = '0; e.st = 3'd3;
    case (opc)
      5'b01100: e.aluop = 2'd2;
      5'b00100: begin e.aluop = 2'd2; e.src = 1'b1; end
      5'b00000, 5'b01000: e.src = 1'b1;
      5'b00101: begin e.src = 1'b1; e.aui = 1'b1; end
      5'b01101: begin e.aluop = 2'd3; e.src = 1'b1; end
      5'b11000: e.aluop = 2'd1;
      default: ;
    endcase
    if (opc == 5'b11000) begin
      e.pcwe = 1'b1; e.ret = 1'b1; e.pcsel = tk ? 2'd1 : 2'd0;
      pp(e, rb(), 1'b1); return;
    end
    if (opc == 5'b11011 || opc == 5'b11001) begin
      e.regwe = 1'b1; e.wbsel = 2'd2; e.pcwe = 1'b1; e.ret = 1'b1;
      e.pcsel = (opc == 5'b11011) ? 2'd1 : 2'd2;
      pp(e, rb(), 1'b1); return;
    end
    pp(e, rb(), 1'b1);
    if (ld || sto) begin
      e.st = 3'd4; e.req = 1'b1; e.we = sto;
      for (int i = 0; i < mw; i++) pp(e, 1'b0, 1'b1);
      if (sto) begin e.pcwe = 1'b1; e.ret = 1'b1; pp(e, 1'b1, 1'b1); return; end
      pp(e, 1'b1, 1'b1);
    end
    e = '0; e.st = 3'd5; e.regwe = 1'b1; e.wbsel = ld ? 2'd1 : 2'd0;
    e.pcwe = 1'b1; e.ret = 1'b1;
    pp(e, rb(), 1'b0);
  endtask

  task automatic step(input rec_t ea, input rec_t eb, input bit r, input bit chk);
    ent_t e;
    mem_ready = r;
    e.a = ea; e.b = eb; e.achk = chk;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [4:0] opc, input bit tk, input int fw, input int mw);
    rec_t la[$];
    bit   lr[$];
    bit   lc[$];
    plan(opc, tk, fw, mw, 1'b1);
    la = pl; lr = pr; lc = pc;
    plan(opc, tk, fw, mw, 1'b0);
    opcode = opc; branch_taken = tk; funct3 = 3'($urandom);
    for (int i = 0; i < la.size(); i++) step(la[i], pl[i], lr[i], lc[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    cmp("dutA_in_reset", act_a(), rec_t'(0), 1'b1);
    cmp("dutB_in_reset", act_b(), rec_t'(0), 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(rec_t'(0), rec_t'(0), 1'b0, 1'b1);
  endtask

  initial begin
    logic [4:0] legal [10];
    rec_t m;
    legal = '{5'b00000, 5'b01000, 5'b11000, 5'b11001, 5'b11011,
              5'b00100, 5'b01100, 5'b00101, 5'b01101, 5'b10001};
    #2;
    do_reset();

    // Hand-computed latencies pin the trace model itself.
    plan(5'b01100, 1'b0, 0, 0, 1'b1);
    chk_lit("model_add_len", pl.size(), 4);
    chk_lit("model_add_retire_state", int'(pl[3].st), 5);
    plan(5'b00000, 1'b0, 2, 2, 1'b1);
    chk_lit("model_lw_len", pl.size(), 9);
    chk_lit("model_lw_wbsel", int'(pl[8].wbsel), 1);
    plan(5'b11000, 1'b1, 0, 0, 1'b1);
    chk_lit("model_beq_len", pl.size(), 3);
    chk_lit("model_beq_pcsel", int'(pl[2].pcsel), 1);

    // Directed flows
    run_instr(5'b01100, 1'b0, 0, 0);
    run_instr(5'b00000, 1'b0, 2, 2);
    run_instr(5'b11000, 1'b1, 0, 0);
    run_instr(5'b11000, 1'b0, 0, 0);
    run_instr(5'b00100, 1'b0, 4, 0);   // ready on the timeout cycle wins
    run_instr(5'b00000, 1'b0, 1, 4);
    run_instr(5'b01000, 1'b0, 0, 4);

    // Illegal opcode: A halts, B treats it as a NOP.
    run_instr(5'b11111, 1'b0, 1, 0);
    step(r_halt(1'b1, 1'b0), r_fetch(), 1'b0, 1'b1);
    step(r_halt(1'b1, 1'b0), r_fetch(), 1'b0, 1'b1);
    do_reset();

    // SYSTEM halts both without marking illegal.
    run_instr(5'b11100, 1'b0, 0, 0);
    step(r_halt(1'b0, 1'b0), r_halt(1'b0, 1'b0), 1'b0, 1'b1);
    do_reset();

    // Fetch watchdog: A halts after request cycle 5 (count reaches 4).
    for (int i = 0; i < 5; i++) step(r_fetch(), r_fetch(), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(r_halt(1'b0, 1'b1), r_fetch(), 1'b0, 1'b1);
    do_reset();

    // MEM watchdog on a load.
    plan(5'b00000, 1'b0, 0, 0, 1'b1);
    opcode = 5'b00000;
    for (int i = 0; i < 3; i++) step(pl[i], pl[i], pr[i], 1'b1);
    m = '0; m.st = 3'd4; m.req = 1'b1; m.src = 1'b1;
    for (int i = 0; i < 5; i++) step(m, m, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(r_halt(1'b0, 1'b1), m, 1'b0, 1'b1);
    do_reset();

    // Reset asserted in the middle of a store's memory wait.
    plan(5'b01000, 1'b0, 0, 3, 1'b1);
    opcode = 5'b01000;
    for (int i = 0; i < 4; i++) step(pl[i], pl[i], pr[i], 1'b1);
    mem_ready = 1'b0;
    #2;
    chk_lit("store_mem_req_before_reset", int'(a_req), 1);
    chk_lit("store_mem_we_before_reset", int'(a_we), 1);
    do_reset();

    // Randomized legal instruction stream.
    ret_a = 0; ret_b = 0;
    for (int n = 0; n < 150; n++)
      run_instr(legal[$urandom_range(0, 9)], rb(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    chk_lit("dutA_retire_count", ret_a, 150);
    chk_lit("dutB_retire_count", ret_b, 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
